// File: rtl/vga_crtc_update_master.sv
// vga_crtc_update_master
// Bus initiator that reprograms the CRTC cursor registers (0xA, 0xB, 0xE, 0xF)
// through the VGA index/value word port, optionally waiting for vertical
// retrace first by polling the input status register. Every bus access is
// followed by a one-cycle GAP so a registered ack that lingers is never
// mistaken for the ack of the next access.
module vga_crtc_update_master #(
    parameter logic [18:0] BASE_ADDR   = 19'h001E8,
    parameter int          POLL_LIMIT  = 1024,
    parameter int          ACK_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wait_vsync,
    input  logic [1:0]  cursor_mode,
    input  logic [2:0]  scan_start,
    input  logic [2:0]  scan_end,
    input  logic [14:0] cursor_pos,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        vsync_timeout,
    output logic [18:0] m_addr,
    output logic [15:0] m_data_out,
    input  logic [15:0] m_data_in,
    output logic [1:0]  m_bytesel,
    output logic        m_wr_en,
    output logic        m_access,
    input  logic        m_ack
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] POLL  = 3'd1;
    localparam logic [2:0] WRITE = 3'd2;
    localparam logic [2:0] GAP   = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [2:0] ERR   = 3'd5;

    localparam int PW = $clog2(POLL_LIMIT + 1);
    localparam int AW = $clog2(ACK_TIMEOUT + 1);

    logic [2:0]  state_reg;
    logic [2:0]  gap_next_reg;     // where GAP goes once the idle cycle has passed
    logic [1:0]  k_reg;            // index of the CRTC write in progress
    logic [PW-1:0] poll_cnt_reg;
    logic [AW-1:0] ack_cnt_reg;    // cycles the current access has waited for ack
    logic        vsync_timeout_reg;
    logic [1:0]  mode_reg;
    logic [2:0]  start_reg;
    logic [2:0]  end_reg;
    logic [13:0] pos_reg;

    logic        ack_expired;
    logic        unused_bits;

    // Only status bit 3 (vertical retrace) and cursor address bits [13:0] matter.
    assign unused_bits = cursor_pos[14] ^ (^m_data_in[15:4]) ^ (^m_data_in[2:0]);

    assign ack_expired = (ack_cnt_reg == AW'(ACK_TIMEOUT - 1));

    // Sequencer: accept, retrace polling, four writes, watchdog abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            gap_next_reg      <= IDLE;
            k_reg             <= 2'd0;
            poll_cnt_reg      <= '0;
            ack_cnt_reg       <= '0;
            vsync_timeout_reg <= 1'b0;
            mode_reg          <= 2'd0;
            start_reg         <= 3'd0;
            end_reg           <= 3'd0;
            pos_reg           <= 14'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        mode_reg          <= cursor_mode;
                        start_reg         <= scan_start;
                        end_reg           <= scan_end;
                        pos_reg           <= cursor_pos[13:0];
                        vsync_timeout_reg <= 1'b0;
                        k_reg             <= 2'd0;
                        poll_cnt_reg      <= '0;
                        ack_cnt_reg       <= '0;
                        state_reg         <= wait_vsync ? POLL : WRITE;
                    end
                end
                POLL: begin
                    if (m_ack) begin
                        ack_cnt_reg <= '0;
                        state_reg   <= GAP;
                        if (m_data_in[3]) begin
                            gap_next_reg <= WRITE;
                        end else if (poll_cnt_reg == PW'(POLL_LIMIT - 1)) begin
                            // Give up on retrace but still apply the update.
                            vsync_timeout_reg <= 1'b1;
                            gap_next_reg      <= WRITE;
                        end else begin
                            poll_cnt_reg <= poll_cnt_reg + 1'b1;
                            gap_next_reg <= POLL;
                        end
                    end else if (ack_expired) begin
                        state_reg <= ERR;
                    end else begin
                        ack_cnt_reg <= ack_cnt_reg + 1'b1;
                    end
                end
                WRITE: begin
                    if (m_ack) begin
                        ack_cnt_reg  <= '0;
                        state_reg    <= GAP;
                        gap_next_reg <= (k_reg == 2'd3) ? DONE : WRITE;
                        k_reg        <= k_reg + 1'b1;
                    end else if (ack_expired) begin
                        state_reg <= ERR;
                    end else begin
                        ack_cnt_reg <= ack_cnt_reg + 1'b1;
                    end
                end
                GAP:     state_reg <= gap_next_reg;
                DONE:    state_reg <= IDLE;
                ERR:     state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Bus signals decoded from state so they stay stable for the whole access.
    always_comb begin
        m_access   = 1'b0;
        m_wr_en    = 1'b0;
        m_addr     = 19'd0;
        m_data_out = 16'd0;
        m_bytesel  = 2'b00;
        case (state_reg)
            POLL: begin
                m_access  = 1'b1;
                m_addr    = BASE_ADDR + 19'd5;
                m_bytesel = 2'b01;
            end
            WRITE: begin
                m_access  = 1'b1;
                m_wr_en   = 1'b1;
                m_addr    = BASE_ADDR + 19'd2;
                m_bytesel = 2'b11;
                case (k_reg)
                    2'd0:    m_data_out = {2'b00, mode_reg, 1'b0, start_reg, 8'h0A};
                    2'd1:    m_data_out = {5'b00000, end_reg, 8'h0B};
                    2'd2:    m_data_out = {2'b00, pos_reg[13:8], 8'h0E};
                    default: m_data_out = {pos_reg[7:0], 8'h0F};
                endcase
            end
            default: ;
        endcase
    end

    assign busy          = (state_reg != IDLE);
    assign done          = (state_reg == DONE);
    assign error         = (state_reg == ERR);
    assign vsync_timeout = vsync_timeout_reg;

endmodule

// File: tb/tb_vga_crtc_update_master.sv
// Bench for vga_crtc_update_master: a configurable bus target, a transaction
// monitor and a reference model that derives the expected access list from
// the register map and the retrace-poll rules.
module tb_vga_crtc_update_master;

    localparam logic [18:0] BASE = 19'h001E8;
    localparam int PLIM = 4;
    localparam int ATO  = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        wait_vsync;
    logic [1:0]  cursor_mode;
    logic [2:0]  scan_start;
    logic [2:0]  scan_end;
    logic [14:0] cursor_pos;
    logic        busy, done, error, vsync_timeout;
    logic [18:0] m_addr;
    logic [15:0] m_data_out;
    logic [15:0] m_data_in;
    logic [1:0]  m_bytesel;
    logic        m_wr_en, m_access, m_ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_crtc_update_master #(.BASE_ADDR(BASE), .POLL_LIMIT(PLIM), .ACK_TIMEOUT(ATO)) dut (
        .clk(clk), .reset(reset), .req(req), .wait_vsync(wait_vsync),
        .cursor_mode(cursor_mode), .scan_start(scan_start), .scan_end(scan_end),
        .cursor_pos(cursor_pos), .busy(busy), .done(done), .error(error),
        .vsync_timeout(vsync_timeout), .m_addr(m_addr), .m_data_out(m_data_out),
        .m_data_in(m_data_in), .m_bytesel(m_bytesel), .m_wr_en(m_wr_en),
        .m_access(m_access), .m_ack(m_ack)
    );

    // ---------------- target model ----------------
    int          wait_cyc   = 0;   // wait cycles before ack
    int          hold_extra = 0;   // extra cycles ack stays high
    int          nak_write  = -1;  // index of write that is never acked
    logic [31:0] stat_bits  = 32'd0; // bit3 value returned by the n-th status read
    int          wcnt = 0, extra_left = 0, poll_idx = 0, writes_acked = 0;
    logic [15:0] rd_word;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ack      <= 1'b0;
            wcnt       <= 0;
            extra_left <= 0;
        end else begin
            if (req && !busy) begin
                poll_idx     <= 0;
                writes_acked <= 0;
            end
            if (m_ack && extra_left > 0) begin
                extra_left <= extra_left - 1;
            end else if (m_ack) begin
                m_ack <= 1'b0;
            end else if (m_access) begin
                if (m_wr_en && writes_acked == nak_write) begin
                    wcnt <= 0;
                end else if (wcnt >= wait_cyc) begin
                    m_ack      <= 1'b1;
                    extra_left <= hold_extra;
                    wcnt       <= 0;
                    rd_word     = 16'($urandom);
                    if (m_wr_en) begin
                        writes_acked <= writes_acked + 1;
                    end else begin
                        rd_word[3] = (poll_idx < 32) ? stat_bits[poll_idx] : 1'b0;
                        poll_idx  <= poll_idx + 1;
                    end
                    m_data_in <= rd_word;
                end else begin
                    wcnt <= wcnt + 1;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    logic [37:0] log_q[$];
    logic [37:0] exp_q[$];
    int run = 0, last_run = 0, starts = 0;
    logic prev_acc = 1'b0;

    always @(posedge clk) begin
        if (m_access && m_ack) begin
            log_q.push_back({m_wr_en, m_bytesel, m_addr, m_wr_en ? m_data_out : 16'h0000});
            $display("txn %s addr=%05h be=%b data=%04h", m_wr_en ? "WR" : "RD",
                     m_addr, m_bytesel, m_wr_en ? m_data_out : m_data_in);
        end
        if (m_access) run = run + 1;
        else if (run > 0) begin last_run = run; run = 0; end
        if (m_access && !prev_acc) starts = starts + 1;
        prev_acc = m_access;
    end

    // ---------------- reference model ----------------
    function automatic void build_exp(input logic wv, input logic [1:0] md, input logic [2:0] ss,
                                      input logic [2:0] se, input logic [14:0] pos,
                                      output logic exp_to);
        int n;
        bit found;
        logic [15:0] w [4];
        n = 0;
        found = 0;
        exp_q.delete();
        exp_to = 1'b0;
        if (wv) begin
            for (int i = 0; i < PLIM; i++) begin
                n++;
                if (stat_bits[i]) begin found = 1; break; end
            end
            exp_to = !found;
            for (int i = 0; i < n; i++) exp_q.push_back({1'b0, 2'b01, BASE + 19'd5, 16'h0000});
        end
        w[0] = (16'(md) << 12) | (16'(ss) << 8) | 16'h000A;
        w[1] = (16'(se) << 8) | 16'h000B;
        w[2] = (16'(pos) & 16'h3F00) | 16'h000E;
        w[3] = ((16'(pos) & 16'h00FF) << 8) | 16'h000F;
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 2'b11, BASE + 19'd2, w[i]});
    endfunction

    // Issue one request and wait for done/error; optionally disturb inputs and req while busy.
    task automatic run_seq(input logic wv, input logic [1:0] md, input logic [2:0] ss,
                           input logic [2:0] se, input logic [14:0] pos, input bit scramble,
                           output int done_cyc, output int err_cyc, output logic busy1);
        log_q.delete();
        @(negedge clk);
        wait_vsync = wv; cursor_mode = md; scan_start = ss; scan_end = se; cursor_pos = pos;
        req = 1'b1;
        @(posedge clk);
        #1;
        req   = 1'b0;
        busy1 = busy;
        if (scramble) begin
            wait_vsync = ~wv; cursor_mode = ~md; scan_start = ~ss; scan_end = ~se;
            cursor_pos = ~pos; req = 1'b1;
        end
        done_cyc = -1;
        err_cyc  = -1;
        for (int cyc = 1; cyc < 400; cyc++) begin
            @(negedge clk);
            if (cyc == 5) req = 1'b0;
            if (done) begin done_cyc = cyc; break; end
            if (error) begin err_cyc = cyc; break; end
        end
        req = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; req = 1'b0; wait_vsync = 1'b0; cursor_mode = 2'd0;
        scan_start = 3'd0; scan_end = 3'd0; cursor_pos = 15'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, error, vsync_timeout, m_access, m_wr_en} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 000000",
                     {busy, done, error, vsync_timeout, m_access, m_wr_en});
        end
        checks++;
        if ({m_addr, m_data_out, m_bytesel} !== 37'd0) begin
            errors++;
            $display("FAIL reset_bus got addr=%h data=%h be=%b exp all zero", m_addr, m_data_out, m_bytesel);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int dc, ec;
        logic b1, eto;
        wait_cyc = 0; hold_extra = 0; nak_write = -1;
        build_exp(1'b0, 2'd2, 3'd6, 3'd7, 15'h07D0, eto);
        run_seq(1'b0, 2'd2, 3'd6, 3'd7, 15'h07D0, 1'b0, dc, ec, b1);
        checks++;
        if (b1 !== 1'b1) begin errors++; $display("FAIL basic_busy_t1 got %b exp 1", b1); end
        checks++;
        if (dc != 13) begin errors++; $display("FAIL basic_done_cycle got %0d exp 13", dc); end
        checks++;
        if (log_q.size() != 4) begin
            errors++; $display("FAIL basic_count got %0d exp 4", log_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (log_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL basic_txn%0d got %h exp %h", i, log_q[i], exp_q[i]);
                end
            end
            checks++;
            if ({log_q[0][15:0], log_q[1][15:0], log_q[2][15:0], log_q[3][15:0]} !== 64'h260A_070B_070E_D00F) begin
                errors++;
                $display("FAIL basic_words got %h %h %h %h exp 260a 070b 070e d00f",
                         log_q[0][15:0], log_q[1][15:0], log_q[2][15:0], log_q[3][15:0]);
            end
        end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin errors++; $display("FAIL basic_busy_t14 got busy=%b done=%b exp 0 0", busy, done); end
        checks++;
        if (vsync_timeout !== 1'b0) begin errors++; $display("FAIL basic_vto got %b exp 0", vsync_timeout); end
    endtask

    task automatic test_poll();
        int dc, ec;
        logic b1, eto;
        logic [1:0] md;
        logic [2:0] ss, se;
        logic [14:0] pos;
        md = 2'($urandom); ss = 3'($urandom); se = 3'($urandom); pos = 15'($urandom);
        wait_cyc = 0; hold_extra = 0; nak_write = -1; stat_bits = 32'b100;
        build_exp(1'b1, md, ss, se, pos, eto);
        run_seq(1'b1, md, ss, se, pos, 1'b0, dc, ec, b1);
        checks++;
        if (dc < 0) begin errors++; $display("FAIL poll_done got none exp done"); end
        checks++;
        if (log_q.size() != 7) begin
            errors++; $display("FAIL poll_count got %0d exp 7", log_q.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (log_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL poll_txn%0d got %h exp %h", i, log_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (vsync_timeout !== 1'b0) begin errors++; $display("FAIL poll_vto got %b exp 0", vsync_timeout); end
    endtask

    task automatic test_poll_limit();
        int dc, ec;
        logic b1, eto;
        wait_cyc = 1; hold_extra = 0; nak_write = -1; stat_bits = 32'd0;
        build_exp(1'b1, 2'd1, 3'd3, 3'd5, 15'h1234, eto);
        run_seq(1'b1, 2'd1, 3'd3, 3'd5, 15'h1234, 1'b0, dc, ec, b1);
        checks++;
        if (dc < 0) begin errors++; $display("FAIL plim_done got none exp done"); end
        checks++;
        if (log_q.size() != 8) begin
            errors++; $display("FAIL plim_count got %0d exp 8", log_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (log_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL plim_txn%0d got %h exp %h", i, log_q[i], exp_q[i]);
                end
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (vsync_timeout !== 1'b1) begin errors++; $display("FAIL plim_vto got %b exp 1", vsync_timeout); end
    endtask

    task automatic test_wait_hold();
        int dc, ec, s0;
        logic b1, eto;
        logic [1:0] md;
        logic [2:0] ss, se;
        logic [14:0] pos;
        md = 2'($urandom); ss = 3'($urandom); se = 3'($urandom); pos = 15'($urandom);
        wait_cyc = 3; hold_extra = 1; nak_write = -1; stat_bits = 32'b10;
        build_exp(1'b1, md, ss, se, pos, eto);
        run_seq(1'b1, md, ss, se, pos, 1'b1, dc, ec, b1);
        checks++;
        if (dc < 0) begin errors++; $display("FAIL hold_done got none exp done"); end
        checks++;
        if (log_q.size() != exp_q.size()) begin
            errors++; $display("FAIL hold_count got %0d exp %0d", log_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (log_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL hold_txn%0d got %h exp %h", i, log_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (vsync_timeout !== 1'b0) begin errors++; $display("FAIL hold_vto_cleared got %b exp 0", vsync_timeout); end
        s0 = starts;
        repeat (6) @(negedge clk);
        checks++;
        if (starts != s0 || busy !== 1'b0) begin
            errors++; $display("FAIL hold_idle_after got starts+%0d busy=%b exp +0 0", starts - s0, busy);
        end
    endtask

    task automatic test_ack_timeout();
        int dc, ec, s0;
        logic b1, eto;
        wait_cyc = 0; hold_extra = 0; nak_write = 1;
        build_exp(1'b0, 2'd3, 3'd1, 3'd2, 15'h0ABC, eto);
        run_seq(1'b0, 2'd3, 3'd1, 3'd2, 15'h0ABC, 1'b0, dc, ec, b1);
        checks++;
        if (ec < 0 || dc >= 0) begin errors++; $display("FAIL ato_error got err_cyc=%0d done_cyc=%0d exp error only", ec, dc); end
        s0 = starts;
        @(negedge clk);
        checks++;
        if ({error, done, busy} !== 3'b000) begin
            errors++; $display("FAIL ato_pulse got error=%b done=%b busy=%b exp 0 0 0", error, done, busy);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (last_run != ATO) begin errors++; $display("FAIL ato_len got %0d exp %0d", last_run, ATO); end
        checks++;
        if (log_q.size() != 1 || starts != s0) begin
            errors++; $display("FAIL ato_no_more got txns=%0d starts+%0d exp 1 +0", log_q.size(), starts - s0);
        end else begin
            checks++;
            if (log_q[0] !== exp_q[0]) begin errors++; $display("FAIL ato_txn0 got %h exp %h", log_q[0], exp_q[0]); end
        end
        nak_write = -1;
    endtask

    task automatic test_reset_mid();
        int dc, ec;
        logic b1, eto;
        bit hit;
        logic [1:0] md;
        logic [2:0] ss, se;
        logic [14:0] pos;
        wait_cyc = 2; hold_extra = 0; nak_write = -1;
        log_q.delete();
        @(negedge clk);
        wait_vsync = 1'b0; cursor_mode = 2'd1; scan_start = 3'd2; scan_end = 3'd3; cursor_pos = 15'h0F0F;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        hit = 0;
        for (int i = 0; i < 200; i++) begin
            if (log_q.size() == 2 && m_access) begin hit = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL rstmid_reach got txns=%0d exp 3rd write in progress", log_q.size()); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({m_access, busy, done, error} !== 4'b0000) begin
            errors++; $display("FAIL rstmid_drop got access=%b busy=%b done=%b error=%b exp 0000", m_access, busy, done, error);
        end
        @(negedge clk);
        reset = 1'b0;
        md = 2'($urandom); ss = 3'($urandom); se = 3'($urandom); pos = 15'($urandom);
        wait_cyc = 0;
        build_exp(1'b0, md, ss, se, pos, eto);
        run_seq(1'b0, md, ss, se, pos, 1'b0, dc, ec, b1);
        checks++;
        if (dc != 13) begin errors++; $display("FAIL rstmid_done got %0d exp 13", dc); end
        checks++;
        if (log_q.size() != 4) begin
            errors++; $display("FAIL rstmid_count got %0d exp 4", log_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (log_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL rstmid_txn%0d got %h exp %h", i, log_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        int dc, ec;
        logic b1, eto, wv;
        logic [1:0] md;
        logic [2:0] ss, se;
        logic [14:0] pos;
        for (int it = 0; it < 8; it++) begin
            wv = 1'($urandom); md = 2'($urandom); ss = 3'($urandom); se = 3'($urandom);
            pos = 15'($urandom);
            stat_bits  = $urandom & $urandom & $urandom;
            wait_cyc   = $urandom_range(0, 2);
            hold_extra = $urandom_range(0, 1);
            nak_write  = -1;
            build_exp(wv, md, ss, se, pos, eto);
            run_seq(wv, md, ss, se, pos, 1'($urandom), dc, ec, b1);
            checks++;
            if (dc < 0) begin errors++; $display("FAIL rand%0d_done got none exp done", it); end
            checks++;
            if (log_q.size() != exp_q.size()) begin
                errors++; $display("FAIL rand%0d_count got %0d exp %0d", it, log_q.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    checks++;
                    if (log_q[i] !== exp_q[i]) begin
                        errors++; $display("FAIL rand%0d_txn%0d got %h exp %h", it, i, log_q[i], exp_q[i]);
                    end
                end
            end
            checks++;
            if (vsync_timeout !== eto) begin errors++; $display("FAIL rand%0d_vto got %b exp %b", it, vsync_timeout, eto); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_poll();
        test_poll_limit();
        test_wait_hold();
        test_ack_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
